// File: rtl/tile_writeback_addr_gen_pkg.sv
// Shared geometry and state encoding for the 4x4 tile read/write address generators.
// The read-side counter imports the same constants so both walk identical tiles.
package tile_writeback_addr_gen_pkg;

  localparam int unsigned AddrWDef     = 9;
  localparam int unsigned DataWDef     = 8;
  localparam int unsigned TileDef      = 4;
  localparam int unsigned RowStrideDef = 13;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } wb_state_e;

endpackage

// File: rtl/tile_addr_stepper.sv
// Row-major tile address walker: holds ptr/col/row, loads a base, steps one word per beat.
// After the last word it clears itself so the next tile starts from a clean state.
module tile_addr_stepper
  import tile_writeback_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDef,
  parameter int unsigned TILE       = TileDef,
  parameter int unsigned ROW_STRIDE = RowStrideDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);

  localparam int unsigned CntW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(TILE - 1);
  // Jump from the end of one row to the start of the next; wraps modulo 2^ADDR_W.
  localparam logic [ADDR_W-1:0] RowJump = ADDR_W'(ROW_STRIDE - (TILE - 1));

  logic [ADDR_W-1:0] ptr_q;
  logic [CntW-1:0]   col_q;
  logic [CntW-1:0]   row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (load) begin
      ptr_q <= base;
      col_q <= '0;
      row_q <= '0;
    end else if (step) begin
      if (col_q == LastIdx) begin
        if (row_q == LastIdx) begin
          ptr_q <= '0;
          col_q <= '0;
          row_q <= '0;
        end else begin
          ptr_q <= ptr_q + RowJump;
          col_q <= '0;
          row_q <= row_q + CntW'(1);
        end
      end else begin
        ptr_q <= ptr_q + ADDR_W'(1);
        col_q <= col_q + CntW'(1);
      end
    end
  end

  assign ptr  = ptr_q;
  assign last = (row_q == LastIdx) && (col_q == LastIdx);

endmodule

// File: rtl/tile_writeback_addr_gen.sv
// Tile write-back address generator: accepts TILE*TILE words over valid/ready and
// issues registered memory writes in row-major tile order from a loaded base.
module tile_writeback_addr_gen
  import tile_writeback_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDef,
  parameter int unsigned DATA_W     = DataWDef,
  parameter int unsigned TILE       = TileDef,
  parameter int unsigned ROW_STRIDE = RowStrideDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  wb_state_e state_q, state_d;

  logic              beat;
  logic              load;
  logic              last;
  logic [ADDR_W-1:0] ptr;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              done_q;

  // in_ready is a pure function of state, so beat has no comb path back to in_valid.
  assign beat = in_valid && in_ready;
  assign load = (state_q == StIdle) && start;

  tile_addr_stepper #(
    .ADDR_W     (ADDR_W),
    .TILE       (TILE),
    .ROW_STRIDE (ROW_STRIDE)
  ) u_stepper (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (beat),
    .base (base_addr),
    .ptr  (ptr),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StWrite;
      StWrite: if (beat && last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
      StWrite: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Address/data hold their last value between beats; only the strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      mem_we_q <= beat;
      done_q   <= beat && last;
      if (beat) begin
        mem_addr_q  <= ptr;
        mem_wdata_q <= in_data;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;

endmodule
